acc_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller for the 8-bit accumulator machine. It sits directly upstream of the ALU and drives its control, accumulator, operand and PC inputs. It consumes the ALU result to update the accumulator or the PC. It also owns the unified instruction/data memory interface.

---
 rtl/acc_sequencer_if.sv | 37 +++
 rtl/acc_sequencer.sv | 133 +++++++++++++
 tb/tb_acc_sequencer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acc_sequencer_if.sv
// Memory and ALU bus between the accumulator sequencer and its environment.
// The sequencer side is master; memory and ALU together form the slave side.
interface acc_sequencer_if;
    logic [7:0] memAddr;
    logic [7:0] memReadData;
    logic       memWriteEn;
    logic [7:0] memWriteData;
    logic [1:0] aluControl;
    logic [7:0] aluDataInACC;
    logic [7:0] aluDataIn;
    logic [7:0] aluPc;
    logic [7:0] aluResult;

    modport master (
        output memAddr,
        output memWriteEn,
        output memWriteData,
        output aluControl,
        output aluDataInACC,
        output aluDataIn,
        output aluPc,
        input  memReadData,
        input  aluResult
    );

    modport slave (
        input  memAddr,
        input  memWriteEn,
        input  memWriteData,
        input  aluControl,
        input  aluDataInACC,
        input  aluDataIn,
        input  aluPc,
        output memReadData,
        output aluResult
    );
endinterface

// File: rtl/acc_sequencer.sv
// Fetch/decode/execute controller for the 8-bit accumulator machine.
// Drives the ALU inputs and the unified memory port; updates acc/pc.
module acc_sequencer #(
    parameter logic [7:0] RESET_PC  = 8'h00,
    parameter logic [7:0] RESET_ACC = 8'h00
) (
    input  logic              clk,
    input  logic              reset,
    acc_sequencer_if.master   bus,
    output logic              halted,
    output logic              instrDone
);
    typedef enum logic [2:0] {
        FETCH, DECODE, READ, EXEC, WB, STORE, HALT
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_NAND = 3'b001;
    localparam logic [2:0] OP_BNZ  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_LDA  = 3'b100;
    localparam logic [2:0] OP_STA  = 3'b101;
    localparam logic [2:0] OP_HALT = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    state_t     state;
    logic [7:0] pc;
    logic [7:0] acc;
    logic [7:0] operand;
    logic [7:0] ir;
    logic       mem_we;
    logic [2:0] op;
    logic [7:0] ir_addr;

    assign op      = ir[7:5];
    assign ir_addr = {3'b000, ir[4:0]};

    assign bus.memWriteEn   = mem_we;
    assign bus.memWriteData = acc;
    assign bus.aluControl   = ir[6:5];
    assign bus.aluDataInACC = acc;
    assign bus.aluDataIn    = operand;
    assign bus.aluPc        = pc;

    always_comb begin
        bus.memAddr = pc;
        if (state == READ || state == STORE) begin
            bus.memAddr = ir_addr;
        end
    end

    // Strobes are registered, so they are set on entry to the state
    // in which they must be visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            acc       <= RESET_ACC;
            operand   <= 8'h00;
            ir        <= 8'hE0;
            mem_we    <= 1'b0;
            halted    <= 1'b0;
            instrDone <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            instrDone <= 1'b0;
            unique case (state)
                FETCH: begin
                    state <= DECODE;
                end
                DECODE: begin
                    ir        <= bus.memReadData;
                    instrDone <= (bus.memReadData[7:5] == OP_NOP);
                    state     <= READ;
                end
                READ: begin
                    unique case (op)
                        OP_STA: begin
                            mem_we    <= 1'b1;
                            instrDone <= 1'b1;
                            state     <= STORE;
                        end
                        OP_HALT: begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end
                        OP_NOP: begin
                            pc    <= pc + 8'd1;
                            state <= FETCH;
                        end
                        default: begin
                            state <= EXEC;
                        end
                    endcase
                end
                EXEC: begin
                    operand   <= bus.memReadData;
                    instrDone <= 1'b1;
                    state     <= WB;
                end
                WB: begin
                    unique case (op)
                        OP_ADD, OP_NAND, OP_SLT: begin
                            acc <= bus.aluResult;
                            pc  <= pc + 8'd1;
                        end
                        OP_BNZ: begin
                            pc <= bus.aluResult;
                        end
                        OP_LDA: begin
                            acc <= operand;
                            pc  <= pc + 8'd1;
                        end
                        default: begin
                            pc <= pc + 8'd1;
                        end
                    endcase
                    state <= FETCH;
                end
                STORE: begin
                    pc    <= pc + 8'd1;
                    state <= FETCH;
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_acc_sequencer.sv
// Scoreboard bench for acc_sequencer with a behavioural memory and ALU.
// Directed programs push expected retire/store records; a monitor checks them.
module tb_acc_sequencer;
    logic clk;
    logic reset;
    logic halted;
    logic instrDone;

    acc_sequencer_if bus ();

    acc_sequencer #(
        .RESET_PC  (8'h00),
        .RESET_ACC (8'h00)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .halted    (halted),
        .instrDone (instrDone)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rdata;
    logic       load_en;
    logic [7:0] load_addr;
    logic [7:0] load_data;

    always @(posedge clk) begin
        rdata <= mem[bus.memAddr];
        if (load_en) begin
            mem[load_addr] <= load_data;
        end else if (bus.memWriteEn) begin
            mem[bus.memAddr] <= bus.memWriteData;
        end
    end
    assign bus.memReadData = rdata;

    logic [7:0] alu_res;
    always_comb begin
        alu_res = 8'h00;
        case (bus.aluControl)
            2'b00: alu_res = bus.aluDataInACC + bus.aluDataIn;
            2'b01: alu_res = ~(bus.aluDataInACC & bus.aluDataIn);
            2'b10: alu_res = (bus.aluDataInACC == 8'h00) ?
                             bus.aluPc + 8'd1 : bus.aluDataIn;
            2'b11: alu_res = {7'b0, bus.aluDataInACC < bus.aluDataIn};
            default: alu_res = 8'h00;
        endcase
    end
    assign bus.aluResult = alu_res;

    int tests;
    int fails;
    int we_cnt;
    logic [15:0] ret_q [$];
    logic [15:0] st_q [$];

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Retire monitor: acc/pc are compared in the cycle after instrDone,
    // once the writeback has landed.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (bus.memWriteEn) begin
                if (st_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_store: addr %02h data %02h",
                             bus.memAddr, bus.memWriteData);
                end else begin
                    e = st_q.pop_front();
                    check("store_addr", bus.memAddr, e[15:8]);
                    check("store_data", bus.memWriteData, e[7:0]);
                end
            end
            if (instrDone) begin
                @(negedge clk);
                if (ret_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_retire: acc %02h pc %02h",
                             bus.aluDataInACC, bus.aluPc);
                end else begin
                    e = ret_q.pop_front();
                    check("retire_acc", bus.aluDataInACC, e[15:8]);
                    check("retire_pc", bus.aluPc, e[7:0]);
                end
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic fill(input logic [7:0] d);
        for (int i = 0; i < 256; i++) begin
            poke(i[7:0], d);
        end
    endtask

    task automatic start();
        reset = 1'b0;
    endtask

    task automatic stop();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_halt(input int budget);
        bit done;
        done   = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(negedge clk);
            if (bus.memWriteEn) we_cnt++;
            if (halted) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL halt_timeout: halted %0d required 1", halted);
        end
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && ret_q.size() != 0; i++) begin
            @(negedge clk);
        end
        if (ret_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: %0d pending required 0",
                     ret_q.size());
        end
    endtask

    initial begin
        int cnt;
        int first;
        tests   = 0;
        fails   = 0;
        reset   = 1'b1;
        load_en = 1'b0;
        load_addr = 8'h00;
        load_data = 8'h00;
        @(negedge clk);
        fill(8'hC0);

        repeat (3) begin
            @(negedge clk);
            check("rst_pc", bus.aluPc, 8'h00);
            check("rst_acc", bus.aluDataInACC, 8'h00);
            check("rst_addr", bus.memAddr, 8'h00);
            check("rst_we", {7'b0, bus.memWriteEn}, 8'h00);
            check("rst_halt", {7'b0, halted}, 8'h00);
        end

        // ADD 5 with mem[05]=03, then HALT
        poke(8'h00, 8'h05);
        poke(8'h05, 8'h03);
        ret_q.push_back({8'h03, 8'h01});
        start();
        cnt   = 0;
        first = -1;
        for (int n = 1; n < 8; n++) begin
            @(negedge clk);
            if (instrDone) begin
                cnt++;
                if (first < 0) first = n;
            end
        end
        check("add_done_cnt", cnt[7:0], 8'd1);
        check("add_done_cyc", first[7:0], 8'd4);
        wait_halt(50);
        check("add_acc", bus.aluDataInACC, 8'h03);
        stop();

        // LDA 6 (07), BNZ 8 -> taken to mem[08]=10
        fill(8'hC0);
        poke(8'h00, 8'h86);
        poke(8'h06, 8'h07);
        poke(8'h01, 8'h48);
        poke(8'h08, 8'h10);
        ret_q.push_back({8'h07, 8'h01});
        ret_q.push_back({8'h07, 8'h10});
        start();
        wait_halt(100);
        check("bnz_t_pc", bus.aluPc, 8'h10);
        stop();

        // Same with mem[06]=00 -> falls through to 02
        poke(8'h06, 8'h00);
        ret_q.push_back({8'h00, 8'h01});
        ret_q.push_back({8'h00, 8'h02});
        start();
        wait_halt(100);
        check("bnz_nt_pc", bus.aluPc, 8'h02);
        stop();

        // LDA 6 (5A), STA 9
        fill(8'hC0);
        poke(8'h00, 8'h86);
        poke(8'h06, 8'h5A);
        poke(8'h01, 8'hA9);
        ret_q.push_back({8'h5A, 8'h01});
        ret_q.push_back({8'h5A, 8'h02});
        st_q.push_back({8'h09, 8'h5A});
        start();
        wait_halt(100);
        check("sta_we_cnt", we_cnt[7:0], 8'd1);
        check("sta_mem09", mem[9], 8'h5A);
        check("sta_pc", bus.aluPc, 8'h02);
        stop();

        // HALT at 00 holds, reset exits
        fill(8'hC0);
        start();
        wait_halt(20);
        repeat (20) begin
            @(negedge clk);
            check("hold_halt", {7'b0, halted}, 8'h01);
            check("hold_pc", bus.aluPc, 8'h00);
            check("hold_we", {7'b0, bus.memWriteEn}, 8'h00);
        end
        stop();
        check("unhalt", {7'b0, halted}, 8'h00);
        start();
        check("resume_addr", bus.memAddr, 8'h00);
        @(negedge clk);
        check("resume_halt", {7'b0, halted}, 8'h00);
        stop();

        // Reset in the EXEC cycle of ADD abandons it
        poke(8'h00, 8'h05);
        poke(8'h05, 8'h03);
        start();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (instrDone) cnt++;
        end
        check("abort_done", cnt[7:0], 8'd0);
        check("abort_acc", bus.aluDataInACC, 8'h00);
        check("abort_pc", bus.aluPc, 8'h00);

        // NOP everywhere: pc walks to FF and wraps to 00
        fill(8'hE0);
        for (int i = 1; i <= 256; i++) begin
            ret_q.push_back({8'h00, 8'(i)});
        end
        start();
        wait_drain(1000);
        stop();

        check("ret_q_empty", 8'(ret_q.size()), 8'd0);
        check("st_q_empty", 8'(st_q.size()), 8'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
